// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl
//
// Sequencing controller for the fully-connected classifier stage.
// - Gates the lane-triple feature stream into the FC datapath.
// - Issues one step pulse per remaining output neuron.
// - Captures the signed scores and tracks the arg-max class.
// - Resets the datapath after every image, because the datapath never
//   leaves its calculation state on its own.
//
// Optional feature (macro FC_CTRL_TIMEOUT_EN):
//   A watchdog aborts a stalled S_WAIT after TIMEOUT_CYCLES cycles. It pulses
//   err, holds the datapath in reset for that cycle and returns to S_LOAD.
//   Without the macro, S_WAIT waits indefinitely and err is tied low.
//
// Ports:
//   clk             single clock, rising edge
//   rst             asynchronous, active-high reset
//   in_valid        upstream lane-triple valid (the data bypasses this block)
//   in_ready        controller accepts load beats
//   fc_valid_in     datapath valid_in (load beats and step pulses)
//   fc_rst          datapath synchronous reset
//   fc_valid_out    datapath result strobe
//   fc_out_data     datapath score, signed, sampled only with fc_valid_out
//   decision_valid  one-cycle pulse when a classification is ready
//   decision        arg-max class index
//   max_score       winning score, signed
//   err             one-cycle watchdog-abort pulse
module fc_seq_ctrl #(
  parameter int NUM_INPUT_DATA  = 48,
  parameter int NUM_LANES       = 3,
  parameter int NUM_OUTPUT_DATA = 10,
  parameter int DATA_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  fc_valid_in,
  output logic                  fc_rst,
  input  logic                  fc_valid_out,
  input  logic [DATA_WIDTH-1:0] fc_out_data,
  output logic                  decision_valid,
  output logic [3:0]            decision,
  output logic [DATA_WIDTH-1:0] max_score,
  output logic                  err
);

  localparam int NUM_BEATS = NUM_INPUT_DATA / NUM_LANES;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [3:0]        LAST_IDX  = 4'(NUM_OUTPUT_DATA - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_WAIT,
    S_STEP,
`ifdef FC_CTRL_TIMEOUT_EN
    S_DONE,
    S_ABORT
`else
    S_DONE
`endif
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [BEAT_W-1:0]       beat_cnt;
  logic [3:0]              idx;
  logic [DATA_WIDTH-1:0]   run_max;
  logic [3:0]              run_idx;
  logic                    capture;
  logic                    load_beat;
  logic                    take_new;
  logic [DATA_WIDTH-1:0]   new_max;
  logic [3:0]              new_idx;

`ifdef FC_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]         wd_cnt;
`endif

  // Candidate arg-max after the score currently on fc_out_data. Score 0
  // always seeds the max; later scores must be strictly greater, so ties
  // stay with the lowest index.
  always_comb begin
    take_new = (idx == 4'd0) || ($signed(fc_out_data) > $signed(run_max));
    new_max  = take_new ? fc_out_data : run_max;
    new_idx  = take_new ? idx : run_idx;
  end

  // Next-state and output decode. fc_rst follows rst directly so the
  // datapath is held in reset for the whole time rst is asserted.
  always_comb begin
    state_next     = state;
    in_ready       = 1'b0;
    fc_valid_in    = 1'b0;
    fc_rst         = rst;
    decision_valid = 1'b0;
    err            = 1'b0;
    capture        = 1'b0;
    load_beat      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready    = ~rst;
        fc_valid_in = in_valid & ~rst;
        load_beat   = in_valid;
        if (in_valid && (beat_cnt == LAST_BEAT)) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fc_valid_out) begin
          capture    = 1'b1;
          state_next = (idx == LAST_IDX) ? S_DONE : S_STEP;
        end
`ifdef FC_CTRL_TIMEOUT_EN
        else if (wd_cnt == WD_LAST) begin
          state_next = S_ABORT;
        end
`endif
      end
      S_STEP: begin
        fc_valid_in = 1'b1;
        state_next  = S_WAIT;
      end
      S_DONE: begin
        decision_valid = 1'b1;
        fc_rst         = 1'b1;
        state_next     = S_LOAD;
      end
`ifdef FC_CTRL_TIMEOUT_EN
      S_ABORT: begin
        err        = 1'b1;
        fc_rst     = 1'b1;
        state_next = S_LOAD;
      end
`endif
      default: state_next = S_LOAD;
    endcase
  end

  // State, counters and score tracking. decision/max_score only change on
  // the final capture, so they hold the last result between images.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_LOAD;
      beat_cnt  <= '0;
      idx       <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      decision  <= '0;
      max_score <= '0;
    end else begin
      state <= state_next;
      if (load_beat) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
          idx      <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (capture) begin
        run_max <= new_max;
        run_idx <= new_idx;
        if (idx == LAST_IDX) begin
          decision  <= new_idx;
          max_score <= new_max;
        end else begin
          idx <= idx + 1'b1;
        end
      end
`ifdef FC_CTRL_TIMEOUT_EN
      if (state == S_ABORT) begin
        beat_cnt <= '0;
        idx      <= '0;
      end
`endif
    end
  end

`ifdef FC_CTRL_TIMEOUT_EN
  // Watchdog: counts consecutive S_WAIT cycles without a result strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state == S_WAIT) && !fc_valid_out) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb_fc_seq_ctrl
//
// Self-checking bench for fc_seq_ctrl. A small behavioural FC datapath model
// answers the 16th load beat and every step pulse with the next score from
// a per-image table, one cycle later. Vectors of {scores, expected class,
// expected max} are run in a loop; reset, gapped input, back-to-back images
// and (with FC_CTRL_TIMEOUT_EN) the watchdog are hand-written sequences.
module tb_fc_seq_ctrl;

  localparam int DW = 12;

  typedef struct {
    int scores [10];
    int exp_decision;
    int exp_max;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          fc_valid_in;
  logic          fc_rst;
  logic          fc_valid_out = 1'b0;
  logic [DW-1:0] fc_out_data = '0;
  logic          decision_valid;
  logic [3:0]    decision;
  logic [DW-1:0] max_score;
  logic          err;

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;

  vec_t vecs [6];
  int   model_scores [10];
  int   withhold_from = 10;
  int   model_pulses  = 0;

  int mon_beats     = 0;
  int e_edge        = 0;
  int load_pulses   = 0;
  int step_pulses   = 0;
  int dv_count      = 0;
  int prev_dv       = 0;
  int last_dv       = 0;
  int fc_rst_cycles = 0;
  int rst_dv_diff   = 0;
  int err_cycles    = 0;

  fc_seq_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fc_valid_in    (fc_valid_in),
    .fc_rst         (fc_rst),
    .fc_valid_out   (fc_valid_out),
    .fc_out_data    (fc_out_data),
    .decision_valid (decision_valid),
    .decision       (decision),
    .max_score      (max_score),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Edge counter: cyc = number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // FC datapath model: pulse n (1-based) of fc_valid_in since the last
  // fc_rst; pulses 16..25 each produce score n-16 in the following cycle.
  always @(posedge clk) begin
    if (fc_rst) begin
      model_pulses <= 0;
      fc_valid_out <= 1'b0;
    end else begin
      fc_valid_out <= 1'b0;
      if (fc_valid_in) begin
        model_pulses <= model_pulses + 1;
        if (model_pulses >= 15 && (model_pulses - 15) < 10 &&
            (model_pulses - 15) < withhold_from) begin
          fc_valid_out <= 1'b1;
          fc_out_data  <= DW'(model_scores[model_pulses - 15]);
        end
      end
    end
  end

  // Mid-cycle observer: beat/edge bookkeeping and pulse counters.
  always @(negedge clk) begin
    if (rst) begin
      mon_beats <= 0;
    end else begin
      if (in_valid && in_ready) begin
        if (mon_beats == 15) begin
          mon_beats <= 0;
          e_edge    <= cyc + 1;
        end else begin
          mon_beats <= mon_beats + 1;
        end
      end
      if (fc_valid_in && in_ready)  load_pulses <= load_pulses + 1;
      if (fc_valid_in && !in_ready) step_pulses <= step_pulses + 1;
      if (decision_valid) begin
        dv_count <= dv_count + 1;
        prev_dv  <= last_dv;
        last_dv  <= cyc;
      end
      if (fc_rst) fc_rst_cycles <= fc_rst_cycles + 1;
      if (fc_rst != decision_valid) rst_dv_diff <= rst_dv_diff + 1;
      if (err) err_cycles <= err_cycles + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one image of 16 accepted beats, optionally toggling in_valid,
  // then drives hold_valid for the following cycle.
  task automatic applyStimulus(input bit gapped, input bit hold_valid, output int iters);
    int n;
    bit phase;
    n = 0;
    iters = 0;
    phase = 1'b1;
    while (n < 16 && iters < 200) begin
      @(negedge clk);
      in_valid = gapped ? phase : 1'b1;
      phase = ~phase;
      if (in_valid && in_ready) n++;
      iters++;
    end
    checkOutput("load_beats_accepted", n, 16);
    @(negedge clk);
    in_valid = hold_valid;
  endtask

  task automatic waitDecision(output int dv_at);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    dv_at = 0;
    while (!found && n < 80) begin
      @(negedge clk);
      n++;
      if (decision_valid) begin
        found = 1'b1;
        dv_at = cyc;
        in_valid = 1'b0;
      end
    end
    checkOutput("decision_valid_seen", int'(found), 1);
  endtask

  task automatic runVector(input int v);
    int it, dv_at, s0, l0, d0;
    model_scores = vecs[v].scores;
    s0 = step_pulses;
    l0 = load_pulses;
    d0 = dv_count;
    applyStimulus(1'b0, 1'b0, it);
    waitDecision(dv_at);
    checkOutput($sformatf("v%0d_decision", v), int'(decision), vecs[v].exp_decision);
    checkOutput($sformatf("v%0d_max_score", v), int'($signed(max_score)), vecs[v].exp_max);
    checkOutput($sformatf("v%0d_latency", v), dv_at - e_edge, 19);
    @(negedge clk);
    checkOutput($sformatf("v%0d_dv_one_cycle", v), int'(decision_valid), 0);
    checkOutput($sformatf("v%0d_in_ready_back", v), int'(in_ready), 1);
    checkOutput($sformatf("v%0d_step_pulses", v), step_pulses - s0, 9);
    checkOutput($sformatf("v%0d_load_pulses", v), load_pulses - l0, 16);
    checkOutput($sformatf("v%0d_dv_count", v), dv_count - d0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int it, dv_at, err_at, got, n, d0, s0, l0, r0, x0;
    bit found;

    vecs[0].scores = '{-5, 3, 40, 7, -100, 12, 39, 0, 1, 2};
    vecs[0].exp_decision = 2;  vecs[0].exp_max = 40;
    vecs[1].scores = '{-20, -20, -20, -20, -20, -20, -20, -20, -20, -20};
    vecs[1].exp_decision = 0;  vecs[1].exp_max = -20;
    vecs[2].scores = '{-2048, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    vecs[2].exp_decision = 1;  vecs[2].exp_max = -1;
    vecs[3].scores = '{2046, 2046, 2046, 2046, 2046, 2046, 2046, 2046, 2046, 2047};
    vecs[3].exp_decision = 9;  vecs[3].exp_max = 2047;
    vecs[4].scores = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    vecs[4].exp_decision = 0;  vecs[4].exp_max = -2048;
    vecs[5].scores = '{7, -7, 8, 8, -1, 9, 9, 9, 0, -2};
    vecs[5].exp_decision = 5;  vecs[5].exp_max = 9;

    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_fc_rst", int'(fc_rst), 1);
    checkOutput("reset_decision_valid", int'(decision_valid), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_decision", int'(decision), 0);
    checkOutput("reset_max_score", int'(max_score), 0);
    rst = 1'b0;
    #1;
    checkOutput("release_in_ready", int'(in_ready), 1);
    checkOutput("release_fc_rst", int'(fc_rst), 0);

    for (int v = 0; v < 6; v++) begin
      runVector(v);
    end

    // Gapped input, with in_valid then held high through WAIT/STEP.
    model_scores = vecs[1].scores;
    s0 = step_pulses;
    l0 = load_pulses;
    applyStimulus(1'b1, 1'b1, it);
    checkOutput("gap_cycles_to_16_beats", it, 31);
    checkOutput("gap_in_ready_low_after_16", int'(in_ready), 0);
    waitDecision(dv_at);
    checkOutput("gap_decision", int'(decision), 0);
    checkOutput("gap_max_score", int'($signed(max_score)), -20);
    @(negedge clk);
    checkOutput("gap_step_pulses", step_pulses - s0, 9);
    checkOutput("gap_load_pulses", load_pulses - l0, 16);

    // Asynchronous reset in S_WAIT after four scores.
    model_scores = vecs[0].scores;
    d0 = dv_count;
    applyStimulus(1'b0, 1'b0, it);
    got = 0;
    n = 0;
    while (got < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (fc_valid_out) got++;
    end
    checkOutput("rst_scores_before_reset", got, 4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_fc_rst", int'(fc_rst), 1);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_fc_valid_in", int'(fc_valid_in), 0);
    checkOutput("rst_decision_cleared", int'(decision), 0);
    checkOutput("rst_max_score_cleared", int'(max_score), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_hold%0d_dv", i), int'(decision_valid), 0);
      checkOutput($sformatf("rst_hold%0d_fc_rst", i), int'(fc_rst), 1);
    end
    rst = 1'b0;
    #1;
    checkOutput("rst_release_in_ready", int'(in_ready), 1);
    @(negedge clk);
    checkOutput("rst_no_decision", dv_count - d0, 0);
    runVector(0);

    // Back-to-back images with in_valid held high.
    model_scores = vecs[0].scores;
    r0 = fc_rst_cycles;
    x0 = rst_dv_diff;
    applyStimulus(1'b0, 1'b1, it);
    applyStimulus(1'b0, 1'b0, it);
    waitDecision(dv_at);
    @(negedge clk);
    checkOutput("b2b_decision", int'(decision), 2);
    checkOutput("b2b_dv_spacing", last_dv - prev_dv, 36);
    checkOutput("b2b_fc_rst_cycles", fc_rst_cycles - r0, 2);
    checkOutput("b2b_fc_rst_only_with_dv", rst_dv_diff - x0, 0);

`ifdef FC_CTRL_TIMEOUT_EN
    // Watchdog: datapath stops answering after score 3.
    withhold_from = 4;
    model_scores = vecs[0].scores;
    d0 = dv_count;
    applyStimulus(1'b0, 1'b0, it);
    found = 1'b0;
    err_at = 0;
    n = 0;
    while (!found && n < 60) begin
      @(negedge clk);
      n++;
      if (err) begin
        found = 1'b1;
        err_at = cyc;
        checkOutput("wd_fc_rst_with_err", int'(fc_rst), 1);
        checkOutput("wd_no_dv_with_err", int'(decision_valid), 0);
      end
    end
    checkOutput("wd_err_seen", int'(found), 1);
    checkOutput("wd_err_latency", err_at - e_edge, 16);
    @(negedge clk);
    checkOutput("wd_in_ready_after", int'(in_ready), 1);
    checkOutput("wd_err_one_cycle", int'(err), 0);
    checkOutput("wd_no_decision", dv_count - d0, 0);
    withhold_from = 10;
    runVector(0);
    checkOutput("err_cycles_total", err_cycles, 1);
`else
    checkOutput("err_cycles_total", err_cycles, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
